// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared types and constants for the UART transmit path.
//            Provides the transmitter FSM state type and the parity-mode
//            encodings used by the PARITY parameter of uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    // Transmitter frame states, in on-wire order.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4
    } uart_tx_state_t;

    // Parity-mode encodings for the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage : uart_tx_pkg

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Small synchronous first-word-fall-through FIFO buffering bytes
//            waiting to be serialised. The head entry is presented directly
//            from the storage array; full/empty derive from the registered
//            occupancy count only.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            i_push/i_data - write request and data (ignored when full)
//            i_pop         - read request (ignored when empty)
//            o_data        - current head entry
//            o_full/o_empty/o_count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset: entries are only read when the count says
    // they were written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_tx_fifo

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Bytes arrive over a valid/ready handshake,
//            queue in a small FIFO and are serialised LSB first as
//            start + DATA_BITS data + optional parity + stop.
// Ports    : clk, reset - clock, synchronous active-high reset
//            tx_data/tx_valid/tx_ready - input byte handshake
//            io_tx      - serial line, idles high (registered)
//            busy       - frame in progress or bytes queued
//            fifo_count - current input-buffer occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        io_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

    uart_tx_state_t         r_state;
    logic [BAUD_W-1:0]      r_baud;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_io_tx;

    logic [DATA_BITS-1:0]   w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_bit_end;
    logic                   w_pop;
    logic                   w_par_bit;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_valid),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // A byte leaves the FIFO either from idle or at the very end of a stop
    // bit, so consecutive frames run with no idle gap between them.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    // r_par holds the even-parity XOR of the payload captured at pop time.
    assign w_par_bit = (PARITY == PARITY_ODD)  ? ~r_par :
                       (PARITY == PARITY_EVEN) ?  r_par : 1'b1;

    assign tx_ready = !w_full;
    assign io_tx    = r_io_tx;
    assign busy     = (r_state != IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_io_tx <= 1'b1;
        end else begin
            // Baud counter free-runs within a bit and clears at every bit
            // boundary; idle pins it at zero so state entry starts clean.
            r_baud <= w_bit_end ? '0 : r_baud + 1'b1;

            case (r_state)
                IDLE: begin
                    r_baud  <= '0;
                    r_io_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= ^w_head;
                        r_state <= START;
                        r_io_tx <= 1'b0;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_io_tx <= r_shift[0];
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                            if (HAS_PARITY) begin
                                r_state <= PARITY_BIT;
                                r_io_tx <= w_par_bit;
                            end else begin
                                r_state <= STOP;
                                r_io_tx <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_io_tx <= r_shift[1];
                        end
                    end
                end

                PARITY_BIT: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_io_tx <= 1'b1;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_par   <= ^w_head;
                            r_state <= START;
                            r_io_tx <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_io_tx <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_io_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Three instances (no, even and
//            odd parity) share one stimulus stream. A frame-level model
//            schedules each accepted byte as a timed frame and predicts the
//            line level, busy, occupancy and ready on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int NI    = 3;
    localparam int MAXF  = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic [NI-1:0] tx_ready;
    logic [NI-1:0] io_tx;
    logic [NI-1:0] busy;
    logic [2:0]    fifo_count [NI];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[0]), .io_tx(io_tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[1]), .io_tx(io_tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready[2]), .io_tx(io_tx[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));

    // Frame model: every accepted byte becomes a frame with an accept cycle
    // and a start cycle; instance k uses parity mode k.
    int         f_acc   [NI][MAXF];
    int         f_start [NI][MAXF];
    logic [7:0] f_data  [NI][MAXF];
    int         nf      [NI];
    logic       last_acc [NI];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    function automatic int flen(int k);
        return (10 + ((k != 0) ? 1 : 0)) * CPB;
    endfunction

    function automatic int occ(int k, int t);
        int n = 0;
        for (int i = 0; i < nf[k]; i++)
            if (f_acc[k][i] <= t && f_start[k][i] > t) n++;
        return n;
    endfunction

    function automatic logic exp_busy(int k, int t);
        for (int i = 0; i < nf[k]; i++)
            if (f_acc[k][i] <= t && t < f_start[k][i] + flen(k)) return 1'b1;
        return 1'b0;
    endfunction

    // Frame bit b: 0 = start, 1..DB = data LSB first, then parity, then stop.
    function automatic logic exp_line(int k, int t);
        for (int i = 0; i < nf[k]; i++) begin
            if (t >= f_start[k][i] && t < f_start[k][i] + flen(k)) begin
                int b;
                b = (t - f_start[k][i]) / CPB;
                if (b == 0) return 1'b0;
                if (b <= DB) return f_data[k][i][b-1];
                if (k != 0 && b == DB + 1) return (^f_data[k][i]) ^ (k == 2);
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: decide acceptance from the model's pre-edge occupancy,
    // advance, update the model, then compare every instance.
    task automatic tick();
        logic acc [NI];
        for (int k = 0; k < NI; k++)
            acc[k] = !reset && tx_valid && (occ(k, cyc) < DEPTH);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            last_acc[k] = acc[k];
            if (reset) begin
                nf[k] = 0;
            end else if (acc[k] && nf[k] < MAXF) begin
                int st;
                st = cyc + 1;
                if (nf[k] > 0 && f_start[k][nf[k]-1] + flen(k) > st)
                    st = f_start[k][nf[k]-1] + flen(k);
                f_acc[k][nf[k]]   = cyc;
                f_start[k][nf[k]] = st;
                f_data[k][nf[k]]  = tx_data;
                nf[k]++;
            end
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("io_tx%0d", k), io_tx[k], exp_line(k, cyc));
            chk($sformatf("busy%0d", k), busy[k], exp_busy(k, cyc));
            chk($sformatf("fifo_count%0d", k), fifo_count[k], occ(k, cyc));
            chk($sformatf("tx_ready%0d", k), tx_ready[k], occ(k, cyc) < DEPTH);
        end
    endtask

    task automatic run_to(int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy !== '0) && g < 500) begin
            tick();
            g++;
        end
        chk("idle_wait", g < 500, 1);
        tick();
    endtask

    initial begin
        int t0;
        int acc_cyc [7];
        for (int k = 0; k < NI; k++) begin
            nf[k] = 0;
            last_acc[k] = 1'b0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_io_tx", io_tx[0], 1);
        chk("reset_ready", tx_ready[0], 1);
        reset = 1'b0;
        tick();

        // Single byte 0xA5, no parity
        tx_data = 8'hA5; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        t0 = cyc;
        chk("a5_accepted", last_acc[0], 1);
        chk("a5_line_at_accept", io_tx[0], 1);
        tick();
        chk("a5_start_bit", io_tx[0], 0);
        run_to(t0 + 4);
        chk("a5_start_held", io_tx[0], 0);
        tick();
        chk("a5_data_bit0", io_tx[0], 1);
        run_to(t0 + 40);
        chk("a5_stop_bit", io_tx[0], 1);
        chk("a5_busy_end", busy[0], 1);
        tick();
        chk("a5_busy_drop", busy[0], 0);
        wait_idle();

        // Back-to-back 0x00 then 0xFF
        tx_data = 8'h00; tx_valid = 1'b1; tick();
        t0 = cyc;
        tx_data = 8'hFF; tick(); tx_valid = 1'b0;
        run_to(t0 + 40);
        chk("b2b_stop1", io_tx[0], 1);
        tick();
        chk("b2b_start2_no_gap", io_tx[0], 0);
        run_to(t0 + 80);
        chk("b2b_busy_last", busy[0], 1);
        tick();
        chk("b2b_busy_drop", busy[0], 0);
        wait_idle();

        // FIFO full: hold valid through bytes 1..6
        for (int b = 1; b <= 6; b++) begin
            int g = 0;
            tx_data = 8'(b);
            tx_valid = 1'b1;
            do begin
                tick();
                g++;
            end while (!last_acc[0] && g < 200);
            chk("full_accept_wait", g < 200, 1);
            acc_cyc[b] = cyc;
            if (b == 5) chk("full_ready_low", tx_ready[0], 0);
        end
        tx_valid = 1'b0;
        chk("full_five_consecutive", acc_cyc[5] - acc_cyc[1], 4);
        chk("full_sixth_after_pop2", acc_cyc[6] - acc_cyc[1], 42);
        wait_idle();

        // Parity: 0x07 has odd weight -> even bit 1, odd bit 0
        tx_data = 8'h07; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        t0 = cyc;
        run_to(t0 + 38);
        chk("parity_even", io_tx[1], 1);
        chk("parity_odd", io_tx[2], 0);
        run_to(t0 + 44);
        chk("parity_busy_last", busy[1], 1);
        tick();
        chk("parity_frame_44", busy[1], 0);
        wait_idle();

        // Reset mid-frame with a second byte queued
        tx_data = 8'h3C; tx_valid = 1'b1; tick();
        t0 = cyc;
        tx_data = 8'h5A; tick(); tx_valid = 1'b0;
        run_to(t0 + 10);
        chk("midframe_line_low", io_tx[0], 0);
        reset = 1'b1; tick();
        chk("midrst_io_tx", io_tx[0], 1);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_count", fifo_count[0], 0);
        chk("midrst_ready", tx_ready[0], 1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        tx_valid = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_tx

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the outbound counterpart of the CPU's io_rx receive path.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto io_tx as 8N1 by default, with optional parity.
- Sits beside the cpu top level. The core or a debug/loader block pushes bytes; io_tx goes to the board pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range ≥2.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 4, entries in the input buffer; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept; a transfer occurs on any edge where tx_valid && tx_ready.
- io_tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - io_tx=1, busy=0, fifo_count=0, tx_ready=1.
  - State=IDLE; baud and bit counters cleared; FIFO pointers cleared.
- Reset mid-frame: the frame is abandoned and FIFO contents are discarded. io_tx returns high on the same edge.
- tx_ready = !full, derived from the registered count only.
  - When the FIFO is full and a pop happens the same cycle, the push is still refused; tx_ready rises next cycle.
  - Data presented while tx_ready=0 is ignored; no overwrite occurs.
- FIFO: first-word fall-through from its own registers. Simultaneous push and pop when non-full and non-empty leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY_BIT, STOP. io_tx is a registered output, updated on the same edge as the state change.
  - IDLE: io_tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, io_tx<=0.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with io_tx<=shift[0].
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles and sent LSB first. The shift register shifts right per bit.
    - bit_cnt counts 0..DATA_BITS-1.
    - After the last bit, go to PARITY_BIT if PARITY≠0, else STOP.
  - PARITY_BIT: io_tx = XOR of the payload (even) or its inverse (odd). Hold CLKS_PER_BIT cycles, then go to STOP.
  - STOP: io_tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears at every bit boundary and state entry.
- Latency: byte accepted on edge N with the FIFO empty and state IDLE → pop and START on edge N+1. io_tx is low from edge N+1 to edge N+1+CLKS_PER_BIT.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + 1) × CLKS_PER_BIT cycles exactly.
- busy = (state≠IDLE) || (fifo_count≠0).

Decomposition:
- Add uart_tx_state_t enum (IDLE, START, DATA, PARITY_BIT, STOP) and the PARITY_NONE/EVEN/ODD constants to the common package.
- Sub-module: uart_tx_fifo (parameterised sync FIFO, push/pop/full/empty/count).
- The FSM and baud logic stay in uart_tx.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless noted):
- Reset: assert reset 3 cycles mid-frame → io_tx=1 on the next edge; busy=0, fifo_count=0, tx_ready=1.
- Single byte: push 0xA5, PARITY=0 → io_tx levels 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles. The start bit begins 1 edge after acceptance; busy drops after 40 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles → the second start bit immediately follows the first stop bit with no idle cycle; total busy = 80 cycles.
- FIFO full: hold tx_valid with 6 bytes 0x01..0x06, FIFO_DEPTH=4 → 5 accepted (1 popped + 4 buffered) and tx_ready=0 while full. The 6th is accepted only after the second pop, and bytes emerge in order.
- Parity: PARITY=1, push 0x07 → parity bit=1. PARITY=2, push 0x07 → parity bit=0. Frame = 44 cycles.
- Push while full with a simultaneous pop: on the edge where STOP→START pops, tx_valid with 0x99 is refused; 0x99 is accepted on the next cycle.
